// File: rtl/melody_game_core.sv
// melody_game_core: melody-memory game engine. Plays a growing melody prefix,
// then checks the player's keypad echo in forward or reverse order.
module melody_game_core #(
  parameter int unsigned NOTES     = 8,
  parameter int unsigned NOTE_W    = 3,
  parameter int unsigned TICK_DIV  = 5_000_000,
  parameter int unsigned START_LEN = 2,
  parameter int unsigned LIVES     = 3,
  localparam int unsigned LW = $clog2(NOTES + 1),
  localparam int unsigned HW = $clog2(LIVES + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [NOTES*NOTE_W-1:0] melody_in,
  input  logic                    start,
  input  logic                    reverse,
  input  logic                    key_valid,
  input  logic [NOTE_W-1:0]       key_note,
  output logic [NOTE_W-1:0]       tone_out,
  output logic [NOTE_W-1:0]       led_out,
  output logic                    playing,
  output logic                    awaiting_input,
  output logic [LW-1:0]           level,
  output logic [HW-1:0]           lives_left,
  output logic                    hit,
  output logic                    miss,
  output logic                    game_won,
  output logic                    game_over
);

  localparam int unsigned PW = $clog2(NOTES);
  localparam int unsigned DW = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    IDLE, PLAY_ON, PLAY_OFF, LISTEN, ECHO, WON, LOST
  } state_t;

  state_t                    state_q, state_d;
  logic [NOTES*NOTE_W-1:0]   melody_q, melody_d;
  logic                      loaded_q, loaded_d;
  logic [LW-1:0]             level_q, level_d;
  logic [HW-1:0]             lives_q, lives_d;
  logic [PW-1:0]             ptr_q, ptr_d;
  logic [PW-1:0]             aptr_q, aptr_d;
  logic                      rev_q, rev_d;
  logic [DW-1:0]             div_q, div_d;
  logic                      beat_q, beat_d;
  logic [NOTE_W-1:0]         key_q, key_d;
  logic                      match_q, match_d;
  logic                      hit_q, hit_d;
  logic                      miss_q, miss_d;
  logic                      won_q, won_d;
  logic                      over_q, over_d;
  logic                      tick;
  logic                      last_ans;
  logic [NOTE_W-1:0]         note_mem [NOTES];

  // Unpack the captured melody into an indexable note table.
  always_comb begin
    for (int unsigned i = 0; i < NOTES; i++) begin
      note_mem[i] = melody_q[i*NOTE_W +: NOTE_W];
    end
  end

  // Next-state and datapath update for the game sequencer.
  always_comb begin
    state_d  = state_q;
    melody_d = melody_q;
    loaded_d = loaded_q;
    level_d  = level_q;
    lives_d  = lives_q;
    ptr_d    = ptr_q;
    aptr_d   = aptr_q;
    rev_d    = rev_q;
    beat_d   = beat_q;
    key_d    = key_q;
    match_d  = match_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    won_d    = won_q;
    over_d   = over_q;
    tick     = (div_q == DW'(TICK_DIV - 1));
    div_d    = tick ? '0 : div_q + DW'(1);
    last_ans = rev_q ? (aptr_q == '0) : (LW'(aptr_q) == level_q - LW'(1));

    unique case (state_q)
      IDLE, WON, LOST: begin
        if (load) begin
          melody_d = melody_in;
          loaded_d = 1'b1;
        end
        if (start && (loaded_q || load)) begin
          level_d = LW'(START_LEN);
          lives_d = HW'(LIVES);
          ptr_d   = '0;
          aptr_d  = '0;
          won_d   = 1'b0;
          over_d  = 1'b0;
          rev_d   = reverse;
          state_d = PLAY_ON;
        end
      end
      PLAY_ON: begin
        if (tick) begin
          if (beat_q) state_d = PLAY_OFF;
          else        beat_d  = 1'b1;
        end
      end
      PLAY_OFF: begin
        if (tick) begin
          if (!beat_q) begin
            beat_d = 1'b1;
          end else if (LW'(ptr_q) < level_q - LW'(1)) begin
            ptr_d   = ptr_q + PW'(1);
            state_d = PLAY_ON;
          end else begin
            aptr_d  = rev_q ? PW'(level_q - LW'(1)) : '0;
            state_d = LISTEN;
          end
        end
      end
      LISTEN: begin
        if (key_valid) begin
          key_d   = key_note;
          match_d = (key_note == note_mem[aptr_q]);
          hit_d   = (key_note == note_mem[aptr_q]);
          miss_d  = (key_note != note_mem[aptr_q]);
          state_d = ECHO;
        end
      end
      ECHO: begin
        if (tick) begin
          if (match_q) begin
            if (!last_ans) begin
              aptr_d  = rev_q ? aptr_q - PW'(1) : aptr_q + PW'(1);
              state_d = LISTEN;
            end else if (level_q == LW'(NOTES)) begin
              won_d   = 1'b1;
              state_d = WON;
            end else begin
              level_d = level_q + LW'(1);
              ptr_d   = '0;
              state_d = PLAY_ON;
            end
          end else if (lives_q > HW'(1)) begin
            lives_d = lives_q - HW'(1);
            ptr_d   = '0;
            state_d = PLAY_ON;
          end else begin
            lives_d = '0;
            over_d  = 1'b1;
            state_d = LOST;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Every phase starts with a fresh prescaler so phase lengths are exact.
    if (state_d != state_q) begin
      div_d  = '0;
      beat_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      melody_q <= '0;
      loaded_q <= 1'b0;
      level_q  <= '0;
      lives_q  <= '0;
      ptr_q    <= '0;
      aptr_q   <= '0;
      rev_q    <= 1'b0;
      div_q    <= '0;
      beat_q   <= 1'b0;
      key_q    <= '0;
      match_q  <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      won_q    <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      melody_q <= melody_d;
      loaded_q <= loaded_d;
      level_q  <= level_d;
      lives_q  <= lives_d;
      ptr_q    <= ptr_d;
      aptr_q   <= aptr_d;
      rev_q    <= rev_d;
      div_q    <= div_d;
      beat_q   <= beat_d;
      key_q    <= key_d;
      match_q  <= match_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      won_q    <= won_d;
      over_q   <= over_d;
    end
  end

  // Piezo drive: melody note while playing, player's key while echoing.
  always_comb begin
    tone_out = '0;
    if (state_q == PLAY_ON)   tone_out = note_mem[ptr_q];
    else if (state_q == ECHO) tone_out = key_q;
  end

  assign led_out        = tone_out;
  assign playing        = (state_q == PLAY_ON) || (state_q == PLAY_OFF);
  assign awaiting_input = (state_q == LISTEN);
  assign level          = level_q;
  assign lives_left     = lives_q;
  assign hit            = hit_q;
  assign miss           = miss_q;
  assign game_won       = won_q;
  assign game_over      = over_q;

endmodule

// File: tb/tb_melody_game_core.sv
// tb_melody_game_core: directed bench with scoreboard queues for melody
// playback and hit/miss outcomes.
module tb_melody_game_core;
  localparam int unsigned NOTES     = 4;
  localparam int unsigned NOTE_W    = 3;
  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned START_LEN = 2;
  localparam int unsigned LIVES     = 2;
  localparam int unsigned LW = $clog2(NOTES + 1);
  localparam int unsigned HW = $clog2(LIVES + 1);

  logic                    clk = 1'b0;
  logic                    reset, load, start, reverse, key_valid;
  logic [NOTES*NOTE_W-1:0] melody_in;
  logic [NOTE_W-1:0]       key_note;
  logic [NOTE_W-1:0]       tone_out, led_out;
  logic                    playing, awaiting_input, hit, miss, game_won, game_over;
  logic [LW-1:0]           level;
  logic [HW-1:0]           lives_left;

  int unsigned mel [NOTES] = '{1, 2, 3, 4};
  int unsigned exp_note_q [$];
  bit          exp_hit_q [$];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  melody_game_core #(
    .NOTES(NOTES), .NOTE_W(NOTE_W), .TICK_DIV(TICK_DIV),
    .START_LEN(START_LEN), .LIVES(LIVES)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .melody_in(melody_in),
    .start(start), .reverse(reverse), .key_valid(key_valid), .key_note(key_note),
    .tone_out(tone_out), .led_out(led_out), .playing(playing),
    .awaiting_input(awaiting_input), .level(level), .lives_left(lives_left),
    .hit(hit), .miss(miss), .game_won(game_won), .game_over(game_over)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic queue_level(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_note_q.push_back(mel[i]);
  endtask

  task automatic start_game(input bit with_load, input bit rev);
    load = with_load; melody_in = 12'h8D1; start = 1'b1; reverse = rev;
    step();
    load = 1'b0; start = 1'b0; reverse = 1'b0;
  endtask

  // Checks a full playback against queued notes; optionally pokes a key mid-note.
  task automatic play_check(input bit inject);
    int unsigned n;
    bit first;
    first = 1'b1;
    chk("sb_notes_pending", 32'(exp_note_q.size() != 0), 32'd1);
    while (exp_note_q.size() > 0) begin
      n = exp_note_q.pop_front();
      chk("playing_on", 32'(playing), 32'd1);
      chk("led_on", 32'(led_out), n);
      for (int j = 0; j < 2*TICK_DIV; j++) begin
        chk("tone_on", 32'(tone_out), n);
        chk("no_pulse_play", 32'({hit, miss}), 32'd0);
        if (inject && first && j == 2) begin
          key_valid = 1'b1; key_note = NOTE_W'(3);
        end
        step();
        key_valid = 1'b0;
      end
      first = 1'b0;
      chk("playing_off", 32'(playing), 32'd1);
      for (int j = 0; j < 2*TICK_DIV; j++) begin
        chk("tone_off", 32'(tone_out), 32'd0);
        step();
      end
    end
    chk("awaiting_after_play", 32'(awaiting_input), 32'd1);
    chk("tone_listen", 32'(tone_out), 32'd0);
  endtask

  // One key press in LISTEN; returns at the first cycle of the following state.
  task automatic press(input int unsigned k, input bit exp_hit, input bit inject);
    bit e;
    exp_hit_q.push_back(exp_hit);
    chk("listen_before_key", 32'(awaiting_input), 32'd1);
    key_valid = 1'b1; key_note = NOTE_W'(k);
    step();
    key_valid = 1'b0; key_note = '0;
    e = exp_hit_q.pop_front();
    chk("hit", 32'(hit), 32'(e));
    chk("miss", 32'(miss), 32'(!e));
    chk("echo_tone", 32'(tone_out), k);
    chk("echo_led", 32'(led_out), k);
    chk("await_drop", 32'(awaiting_input), 32'd0);
    if (inject) begin
      key_valid = 1'b1; key_note = NOTE_W'(k);
    end
    step();
    key_valid = 1'b0; key_note = '0;
    chk("pulse_width", 32'({hit, miss}), 32'd0);
    chk("echo_hold", 32'(tone_out), k);
    repeat (TICK_DIV - 1) step();
    chk("echo_end_tone", 32'(tone_out), 32'(mel[0] * 32'(playing)));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; reverse = 1'b0;
    key_valid = 1'b0; key_note = '0; melody_in = '0;
    repeat (3) step();
    chk("rst_tone", 32'(tone_out), 32'd0);
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_playing", 32'(playing), 32'd0);
    chk("rst_await", 32'(awaiting_input), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_lives", 32'(lives_left), 32'd0);
    chk("rst_pulses", 32'({hit, miss}), 32'd0);
    chk("rst_flags", 32'({game_won, game_over}), 32'd0);
    reset = 1'b0;
    step();

    // start with no melody ever loaded is ignored
    start_game(1'b0, 1'b0);
    chk("noload_playing", 32'(playing), 32'd0);
    chk("noload_level", 32'(level), 32'd0);
    repeat (5) step();
    chk("noload_still_idle", 32'({playing, awaiting_input}), 32'd0);
    chk("noload_tone", 32'(tone_out), 32'd0);

    // forward game to a win, with stray keys during PLAY_ON and ECHO
    queue_level(2);
    start_game(1'b1, 1'b0);
    chk("fwd_level_start", 32'(level), 32'd2);
    chk("fwd_lives_start", 32'(lives_left), 32'd2);
    play_check(1'b1);
    chk("fwd_level_listen", 32'(level), 32'd2);
    press(1, 1'b1, 1'b0);
    queue_level(3);
    press(2, 1'b1, 1'b1);
    chk("fwd_level3", 32'(level), 32'd3);
    play_check(1'b0);
    press(1, 1'b1, 1'b0);
    press(2, 1'b1, 1'b0);
    queue_level(4);
    press(3, 1'b1, 1'b0);
    chk("fwd_level4", 32'(level), 32'd4);
    play_check(1'b0);
    press(1, 1'b1, 1'b0);
    press(2, 1'b1, 1'b0);
    press(3, 1'b1, 1'b0);
    press(4, 1'b1, 1'b0);
    chk("won_flag", 32'(game_won), 32'd1);
    chk("won_over", 32'(game_over), 32'd0);
    chk("won_playing", 32'(playing), 32'd0);
    chk("won_await", 32'(awaiting_input), 32'd0);
    chk("won_level", 32'(level), 32'd4);
    repeat (3) step();
    chk("won_sticky", 32'(game_won), 32'd1);

    // reverse game from WON using the stored melody, ends in LOST
    queue_level(2);
    start_game(1'b0, 1'b1);
    chk("rev_won_cleared", 32'(game_won), 32'd0);
    chk("rev_level_start", 32'(level), 32'd2);
    chk("rev_lives_start", 32'(lives_left), 32'd2);
    play_check(1'b0);
    press(2, 1'b1, 1'b1);
    queue_level(3);
    press(1, 1'b1, 1'b0);
    chk("rev_level3", 32'(level), 32'd3);
    play_check(1'b0);
    queue_level(3);
    press(1, 1'b0, 1'b0);
    chk("rev_lives1", 32'(lives_left), 32'd1);
    chk("rev_replay_level", 32'(level), 32'd3);
    chk("rev_replay_playing", 32'(playing), 32'd1);
    play_check(1'b0);
    press(1, 1'b0, 1'b0);
    chk("lost_over", 32'(game_over), 32'd1);
    chk("lost_lives", 32'(lives_left), 32'd0);
    chk("lost_playing", 32'(playing), 32'd0);
    chk("lost_won", 32'(game_won), 32'd0);

    // reset in the middle of playback clears everything, including the melody
    start_game(1'b0, 1'b0);
    chk("mid_playing", 32'(playing), 32'd1);
    chk("mid_tone", 32'(tone_out), 32'd1);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_tone", 32'(tone_out), 32'd0);
    chk("mid_rst_playing", 32'(playing), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_lives", 32'(lives_left), 32'd0);
    chk("mid_rst_over", 32'(game_over), 32'd0);
    start_game(1'b0, 1'b0);
    chk("postrst_noload", 32'(playing), 32'd0);
    repeat (4) step();
    chk("postrst_idle", 32'({playing, awaiting_input}), 32'd0);
    chk("postrst_tone", 32'(tone_out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/melody_game_core.md
# melody_game_core

Parametrised melody-memory game engine for the piezo/keypad board. It plays a stored melody prefix of growing length, then checks the player's keypad echo in forward or reverse order. It grows the prefix on success and deducts a life on a miss. The block sits between the melody register loader, the debounced keypad front end and the piezo/LED drivers.

## Interface
- NOTES, 8: maximum melody length (≥2).
- NOTE_W, 3: bits per note; 0 means silence.
- TICK_DIV, 5_000_000: clocks per beat tick (≥2).
- START_LEN, 2: initial prefix length (1..NOTES).
- LIVES, 3: misses allowed before game over (≥1).

Ports (LW = $clog2(NOTES+1), HW = $clog2(LIVES+1)):
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle pulse; captures melody_in.
- melody_in  in  NOTES*NOTE_W  note i at [i*NOTE_W +: NOTE_W].
- start  in  1  one-cycle pulse; begins a game.
- reverse  in  1  answer order mode, sampled on an accepted start; 1 = player echoes last note first.
- key_valid  in  1  one-cycle debounced key pulse.
- key_note  in  NOTE_W  key value, valid with key_valid.
- tone_out  out  NOTE_W  piezo note; 0 = silent.
- led_out  out  NOTE_W  mirrors tone_out.
- playing  out  1  high in PLAY_ON/PLAY_OFF.
- awaiting_input  out  1  high in LISTEN.
- level  out  LW  current prefix length.
- lives_left  out  HW  remaining lives.
- hit, miss  out  1  one-cycle result pulses.
- game_won, game_over  out  1  sticky until next accepted start or reset.

## Operation
- Reset: state IDLE, loaded=0, and every output 0 (including level and lives_left).
- States: IDLE, PLAY_ON, PLAY_OFF, LISTEN, ECHO, WON, LOST.
- load is accepted only in IDLE/WON/LOST. It sets loaded=1 and is ignored in any other state.
- start is accepted only in IDLE/WON/LOST with loaded=1, or with load asserted in the same cycle; in that case the new melody is used.
- On an accepted start:
  - level=START_LEN, lives_left=LIVES, play pointer=0.
  - game_won and game_over are cleared, and the reverse mode is latched.
  - The state goes to PLAY_ON.
- PLAY_ON: tone_out=note[ptr] for 2 ticks, then PLAY_OFF with tone_out=0 for 2 ticks.
  - If ptr < level-1: ptr++ and return to PLAY_ON.
  - Otherwise go to LISTEN, with the answer pointer at 0 (forward) or level-1 (reverse).
- Playback is always in index order 0..level-1.
- LISTEN, on key_valid: compare key_note with note[answer pointer].
  - Next cycle: pulse hit or miss, drive tone_out=led_out=key_note, enter ECHO.
- key_valid outside LISTEN is ignored: no pulse, no state or pointer change.
- ECHO lasts 1 tick, then tone_out=0 and one of:
  - Hit, not the last answer: answer pointer moves one step toward the end (++ forward, -- reverse); go to LISTEN.
  - Hit, last answer, level==NOTES: go to WON, game_won=1.
  - Hit, last answer, level<NOTES: level++, ptr=0, go to PLAY_ON.
  - Miss, lives_left>1: lives_left--, ptr=0, replay the same level (PLAY_ON).
  - Miss, lives_left==1: lives_left=0, go to LOST, game_over=1.
- Melody notes equal to 0 play as silence but must still be matched by key_note==0.
- reset has priority over all inputs in any state.
- Arithmetic: pointers and level never leave 0..NOTES-1 / 1..NOTES, and lives_left never wraps below 0.

## Timing
- Tick prescaler restarts at 0 on every entry to PLAY_ON, PLAY_OFF and ECHO. Phase lengths are therefore exact:
  - PLAY_ON = 2*TICK_DIV cycles.
  - PLAY_OFF = 2*TICK_DIV cycles.
  - ECHO = TICK_DIV cycles.
- start accepted at edge c: tone_out=note[0] and playing=1 from cycle c+1.
- Each played note occupies 4*TICK_DIV cycles; awaiting_input rises on the first cycle after the last PLAY_OFF.
- key_valid at edge k:
  - hit/miss and tone_out valid at k+1, awaiting_input=0 at k+1.
  - The next state begins at k+1+TICK_DIV.
- hit/miss are exactly one cycle wide. game_won/game_over rise on the cycle the WON/LOST state is entered.
- Sync reset at edge r: all outputs 0 from cycle r+1.

## Test plan
Bench settings: NOTES=4, NOTE_W=3, TICK_DIV=4, START_LEN=2, LIVES=2, melody_in=12'h8D1 (notes 1,2,3,4).
- Reset, then start without load -> all outputs stay 0, state stays IDLE.
- load plus start (reverse=0) -> tone_out 1 for 8 cycles, 0 for 8, 2 for 8, 0 for 8; then awaiting_input=1, level=2.
- Forward keys 1,2 -> two hit pulses, level=3, replay 1,2,3. Keys 1,2,3, replay, keys 1,2,3,4 -> game_won=1, playing=0.
- reverse=1 at level 2: keys 2,1 -> hits, level 3. Key 1 first -> miss, lives_left=1, replay level 3. Next miss -> game_over=1, lives_left=0.
- key_valid during PLAY_ON and during ECHO -> no hit/miss, and the answer sequence is unaffected.
- reset mid-playback -> next cycle tone_out=0, playing=0, level=0. A subsequent start without load is ignored.
